// File: rtl/serial_crc8.sv
// gate_xor: XOR built from four NAND gates, the team's standard feedback cell.
module gate_xor (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  logic w_n1, w_n2, w_n3;
  assign w_n1 = ~(i_a & i_b);
  assign w_n2 = ~(i_a & w_n1);
  assign w_n3 = ~(i_b & w_n1);
  assign o_y  = ~(w_n2 & w_n3);
endmodule

// serial_crc8: bit-serial MSB-first CRC generator/checker that forwards the
// message, appends the CRC and reports the final remainder and zero residue.
module serial_crc8 #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = 'h07,
  parameter logic [WIDTH-1:0] INIT = 'h00
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din_valid,
  input  logic             din,
  input  logic             last,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] crc_out,
  output logic             residue_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DATA, APPEND, DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_crc, w_shift, w_next;
  logic [CW-1:0]    r_cnt;
  logic             w_fb;
  gate_xor u_fb (.i_a(din), .i_b(r_crc[WIDTH-1]), .o_y(w_fb));
  assign w_shift = {r_crc[WIDTH-2:0], 1'b0};
  for (genvar i = 0; i < WIDTH; i++) begin : g_tap
    if (POLY[i]) begin : g_x
      gate_xor u_tap (.i_a(w_shift[i]), .i_b(w_fb), .o_y(w_next[i]));
    end else begin : g_p
      assign w_next[i] = w_shift[i];
    end
  end
  // done is still high in the first IDLE cycle, so a start held over from DONE is rejected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_crc        <= INIT;
      r_cnt        <= '0;
      dout         <= 1'b0;
      dout_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      crc_out      <= '0;
      residue_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done       <= 1'b0;
          dout_valid <= 1'b0;
          if (start && !done) begin
            r_crc        <= INIT;
            residue_zero <= 1'b0;
            busy         <= 1'b1;
            r_state      <= DATA;
          end
        end
        DATA: begin
          dout_valid <= din_valid;
          if (din_valid) begin
            r_crc <= w_next;
            dout  <= din;
            if (last) begin
              crc_out      <= w_next;
              residue_zero <= (w_next == '0);
              r_cnt        <= CW'(WIDTH - 1);
              r_state      <= APPEND;
            end
          end
        end
        APPEND: begin
          dout       <= r_crc[WIDTH-1];
          r_crc      <= w_shift;
          dout_valid <= 1'b1;
          r_cnt      <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= DONE;
        end
        DONE: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          dout_valid <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_crc8.md
Name: serial_crc8

Overview:
Bit-serial CRC generator and checker built on the team's NAND-based XOR cell (gate_xor), one instance per feedback tap. It consumes a serial bit stream MSB-first and forwards each bit unchanged. It then appends the WIDTH-bit CRC to the stream and reports the final remainder. The same datapath doubles as a checker: a message followed by its own CRC leaves a zero residue. It sits directly downstream of the XOR gate stage and is the first clocked block in the gate-level datapath.

Parameters:
WIDTH, 8, CRC register width in bits; range 2..16.
POLY, 8'h07, generator polynomial without the implicit x^WIDTH term; bit i set means an XOR tap into crc[i].
INIT, 8'h00, CRC register value loaded on start.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a frame; sampled only in IDLE.
din_valid  input  1  din is a valid message bit this cycle.
din  input  1  serial message bit, MSB-first.
last  input  1  qualifies the final message bit; meaningful only with din_valid.
dout  output  1  registered output stream: message bits, then CRC bits.
dout_valid  output  1  dout carries a valid bit.
busy  output  1  high in DATA and APPEND.
done  output  1  one-cycle pulse in DONE.
crc_out  output  WIDTH  final remainder; held until the next start.
residue_zero  output  1  remainder was all-zero at frame end (checker result); held until the next start.

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, crc register = INIT.
  - dout, dout_valid, busy, done, residue_zero = 0; crc_out = 0.
  - Reset asserted mid-frame aborts the frame immediately; no partial CRC is emitted.
- Feedback per accepted bit:
  - fb = din XOR crc[WIDTH-1].
  - crc <= (crc << 1) XOR (fb ? POLY : 0).
  - Each set POLY bit is one gate_xor instance; the shift is truncated to WIDTH bits.
- IDLE:
  - start=1 -> crc <= INIT, clear residue_zero, state DATA.
  - busy rises on the following cycle.
  - din_valid and last are ignored.
- DATA:
  - din_valid=1: apply the feedback update; dout <= din; dout_valid <= 1. Latency is 1 cycle.
  - din_valid=0: crc holds; dout_valid <= 0; dout holds its value.
  - din_valid=1 and last=1: update as above.
    - The post-update crc value is captured into crc_out.
    - residue_zero <= (post-update crc == 0).
    - Bit counter <= WIDTH-1; state APPEND.
  - last=1 with din_valid=0 is ignored.
  - start is ignored while busy.
- APPEND, for exactly WIDTH cycles:
  - dout <= crc[WIDTH-1]; crc <= crc << 1 (no feedback); dout_valid <= 1.
  - The counter decrements; when it reaches 0, state DONE.
  - din, din_valid, last and start are ignored.
  - With continuous din_valid, dout_valid stays high for N+WIDTH contiguous cycles with no bubble.
- DONE:
  - Lasts one cycle; done=1, busy=0, dout_valid=0; then IDLE.
  - start asserted during DONE is ignored; it must be reasserted in IDLE.
- Boundary conditions:
  - A 1-bit frame (start, then din_valid with last in the first DATA cycle) is legal.
  - Frame length is unbounded; no internal length counter covers DATA.
  - crc_out and residue_zero are stable from the cycle after the last message bit until the next start.

Test Plan:
- Reset mid-APPEND, then byte 0x01 -> the aborted frame emits nothing further: dout_valid, busy and done drop at once with no done pulse. The next frame gives crc_out=0x07.
- Byte 0xFF continuous -> crc_out=0xF3. dout sequence is 1111_1111 then 1111_0011. done pulses on the cycle after the 16th dout bit.
- ASCII "123456789" (72 bits, MSB-first per byte) -> crc_out=0xF4. dout_valid is high for 80 contiguous cycles.
- Checker: bytes 0x01,0x07 as one 16-bit frame -> crc_out=0x00, residue_zero=1. Repeating with 0x01,0x06 -> residue_zero=0.
- Byte 0x01 with din_valid low on alternate cycles, plus last pulsed with din_valid=0 mid-frame -> crc_out=0x07. The stray last is ignored and dout_valid gaps mirror the input gaps. start pulses during DATA, APPEND and DONE have no effect.
